// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Issues word fetches over a req/done handshake
// and hands pc/inst to decode. Define IF_ICACHE_EN for a direct-mapped icache.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_flag_i,
  input  logic [31:0] br_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        hit_s;
  logic [31:0] hit_inst_s;

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("if_fetch: ICACHE_LINES must be a power of two and at least 2");
  end

`ifdef IF_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] line_valid_q;
  logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];
  logic [31:0]             line_data_q [ICACHE_LINES];
  logic [IDX_W-1:0]        rd_idx_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic                    fill_s;

  // Fills use the registered request address, so dropped fetches still land in the right line.
  assign rd_idx_s   = fetch_pc_q[IDX_W+1:2];
  assign wr_idx_s   = mem_addr_q[IDX_W+1:2];
  assign fill_s     = (state_q == WAIT) && mem_done_i;
  assign hit_s      = line_valid_q[rd_idx_s] && (line_tag_q[rd_idx_s] == fetch_pc_q[31:IDX_W+2]);
  assign hit_inst_s = line_data_q[rd_idx_s];

  // Line valid bits: cleared on reset, set by every completed memory fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid_q <= '0;
    end else if (fill_s) begin
      line_valid_q[wr_idx_s] <= 1'b1;
    end
  end

  // Line tag and data storage.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_tag_q[wr_idx_s]  <= mem_addr_q[31:IDX_W+2];
      line_data_q[wr_idx_s] <= mem_inst_i;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_inst_s = 32'h0000_0000;
`endif

  // Next-state and output decode for the fetch FSM; redirect outranks everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (br_flag_i) begin
          fetch_pc_d = br_target_i;
        end else if (hit_s) begin
          inst_d     = hit_inst_s;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = HOLD;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (br_flag_i) begin
          // The outstanding fetch cannot be cancelled; remember to discard its word.
          fetch_pc_d = br_target_i;
          valid_d    = 1'b0;
          if (mem_done_i) begin
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            drop_d = 1'b1;
          end
        end else if (mem_done_i) begin
          mem_req_d = 1'b0;
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d     = mem_inst_i;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = HOLD;
          end
        end else begin
          mem_req_d = mem_req_q;
        end
      end
      HOLD: begin
        if (br_flag_i) begin
          fetch_pc_d = br_target_i;
          valid_d    = 1'b0;
          state_d    = IDLE;
        end else if (stall_i) begin
          valid_d = valid_q;
        end else if (hit_s) begin
          inst_d     = hit_inst_s;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        valid_d   = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      pc_q       <= 32'h0000_0000;
      inst_q     <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus for if_fetch with a fixed-latency memory responder and a
// stream-level model (expected next PC, redirects, stall holds) checked every cycle.
`timescale 1ns/1ps
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MEM_LAT  = 3;
  localparam int          BOUND    = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_flag_i;
  logic [31:0] br_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_inst_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_bad    = 0;

  if_fetch #(.RESET_PC(RESET_PC), .ICACHE_LINES(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_flag_i(br_flag_i), .br_target_i(br_target_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_done_i(mem_done_i),
    .mem_inst_i(mem_inst_i), .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  // Static program memory: address 0 holds addi x1,x0,5; elsewhere a pattern derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input string name, output logic seen_valid);
    int n = 0;
    seen_valid = 1'b0;
    do begin
      tick();
      n++;
      if (inst_valid_o) seen_valid = 1'b1;
    end while (!mem_req_o && n < BOUND);
    if (!mem_req_o) begin
      n_checks++;
      n_bad++;
      $display("FAIL %s: no mem_req_o within %0d cycles", name, BOUND);
    end
  endtask

  task automatic wait_req_low(input string name);
    int n = 0;
    while (mem_req_o && n < BOUND) begin
      tick();
      n++;
    end
    if (mem_req_o) begin
      n_checks++;
      n_bad++;
      $display("FAIL %s: mem_req_o never dropped within %0d cycles", name, BOUND);
    end
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!inst_valid_o && cyc < BOUND);
    if (!inst_valid_o) begin
      n_checks++;
      n_bad++;
      $display("FAIL %s: no inst_valid_o within %0d cycles", name, BOUND);
    end
  endtask

  // Memory responder: done pulses MEM_LAT cycles after the request becomes visible.
  initial begin
    int lat_cnt;
    lat_cnt    = 0;
    mem_done_i = 1'b0;
    mem_inst_i = 32'h0000_0000;
    forever begin
      @(negedge clk);
      mem_done_i = 1'b0;
      if (rst || !mem_req_o) begin
        lat_cnt = 0;
      end else begin
        lat_cnt++;
        if (lat_cnt > MEM_LAT) begin
          mem_done_i = 1'b1;
          mem_inst_i = mem_word(mem_addr_o);
          lat_cnt    = 0;
        end
      end
    end
  end

  // Stream model: the next delivered PC advances by 4 per delivery and jumps to the redirect target.
  initial begin
    logic [31:0] model_pc;
    logic        rst_s, br_s, st_s;
    logic [31:0] tgt_s;
    logic        prev_valid, prev_req;
    logic [31:0] prev_pc, prev_inst, prev_addr;
    model_pc   = RESET_PC;
    prev_valid = 1'b0;
    prev_req   = 1'b0;
    prev_pc    = 32'h0;
    prev_inst  = 32'h0;
    prev_addr  = 32'h0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      br_s  = br_flag_i;
      st_s  = stall_i;
      tgt_s = br_target_i;
      #1;
      if (rst_s) begin
        model_pc = RESET_PC;
        check("m_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("m_rst_req", {31'd0, mem_req_o}, 32'd0);
        check("m_rst_addr", mem_addr_o, 32'd0);
        check("m_rst_pc", pc_o, 32'd0);
        check("m_rst_inst", inst_o, 32'd0);
      end else begin
        if (br_s) begin
          check("m_redirect_valid", {31'd0, inst_valid_o}, 32'd0);
          model_pc = tgt_s;
        end else if (prev_valid && st_s) begin
          check("m_hold_valid", {31'd0, inst_valid_o}, 32'd1);
          check("m_hold_pc", pc_o, prev_pc);
          check("m_hold_inst", inst_o, prev_inst);
        end else if (inst_valid_o) begin
          check("m_deliver_pc", pc_o, model_pc);
          check("m_deliver_inst", inst_o, mem_word(model_pc));
          model_pc = model_pc + 32'd4;
        end
        if (mem_req_o && !prev_req) begin
          check("m_req_addr", mem_addr_o, model_pc);
        end else if (mem_req_o && prev_req) begin
          check("m_req_stable", mem_addr_o, prev_addr);
        end
        if (inst_valid_o) begin
          check("m_no_req_when_valid", {31'd0, mem_req_o}, 32'd0);
        end
      end
      prev_valid = inst_valid_o;
      prev_req   = mem_req_o;
      prev_pc    = pc_o;
      prev_inst  = inst_o;
      prev_addr  = mem_addr_o;
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int   cyc;
    logic seen_v;
    rst = 1'b1; stall_i = 1'b0; br_flag_i = 1'b0; br_target_i = 32'h0;
    tick(); tick();
    check("reset_req", {31'd0, mem_req_o}, 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_pc", pc_o, 32'd0);
    check("reset_inst", inst_o, 32'd0);
    check("reset_valid", {31'd0, inst_valid_o}, 32'd0);

    rst = 1'b0;
    tick();
    check("first_req", {31'd0, mem_req_o}, 32'd1);
    check("first_addr", mem_addr_o, 32'h0000_0000);
    wait_valid("first_inst", cyc);
    check("first_latency", cyc, 32'd4);
    check("first_pc", pc_o, 32'h0000_0000);
    check("first_inst", inst_o, 32'h0050_0093);
    wait_req("second_req", seen_v);
    check("second_addr", mem_addr_o, 32'h0000_0004);

    wait_valid("pc4_inst", cyc);
    check("pc4_pc", pc_o, 32'h0000_0004);
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      check("stall_pc", pc_o, 32'h0000_0004);
      check("stall_inst", inst_o, 32'h0004_FFFB);
      check("stall_no_req", {31'd0, mem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    wait_req("after_stall_req", seen_v);
    check("after_stall_addr", mem_addr_o, 32'h0000_0008);

    br_flag_i = 1'b1; br_target_i = 32'h0000_0100;
    tick();
    br_flag_i = 1'b0;
    check("wait_redirect_req_held", {31'd0, mem_req_o}, 32'd1);
    wait_req_low("drop_done");
    wait_req("redirect_req", seen_v);
    check("dropped_word_hidden", {31'd0, seen_v}, 32'd0);
    check("redirect_addr", mem_addr_o, 32'h0000_0100);
    wait_valid("redirect_inst", cyc);
    check("redirect_pc", pc_o, 32'h0000_0100);
    check("redirect_inst", inst_o, 32'h0100_FEFF);

    stall_i = 1'b1; br_flag_i = 1'b1; br_target_i = 32'h0000_0200;
    tick();
    stall_i = 1'b0; br_flag_i = 1'b0;
    check("br_beats_stall_valid", {31'd0, inst_valid_o}, 32'd0);
    wait_req("br_stall_req", seen_v);
    check("br_stall_addr", mem_addr_o, 32'h0000_0200);
    wait_valid("pc200_inst", cyc);
    check("pc200_inst", inst_o, 32'h0200_FDFF);
    wait_valid("pc204_inst", cyc);
    check("throughput_cycles", cyc, 32'd6);
    check("pc204_pc", pc_o, 32'h0000_0204);

    wait_req("pc208_req", seen_v);
    check("pc208_addr", mem_addr_o, 32'h0000_0208);
    br_flag_i = 1'b1; br_target_i = 32'h0000_0300;
    tick();
    br_target_i = 32'h0000_0400;
    tick();
    br_flag_i = 1'b0;
    wait_req_low("double_drop_done");
    wait_req("newest_target_req", seen_v);
    check("newest_target_hidden", {31'd0, seen_v}, 32'd0);
    check("newest_target_addr", mem_addr_o, 32'h0000_0400);
    wait_valid("pc400_inst", cyc);
    check("pc400_pc", pc_o, 32'h0000_0400);

    wait_req("pc404_req", seen_v);
    check("pc404_addr", mem_addr_o, 32'h0000_0404);
    tick(); tick(); tick();
    br_flag_i = 1'b1; br_target_i = 32'h0000_0500;
    tick();
    br_flag_i = 1'b0;
    check("br_with_done_valid", {31'd0, inst_valid_o}, 32'd0);
    check("br_with_done_req", {31'd0, mem_req_o}, 32'd0);
    wait_req("pc500_req", seen_v);
    check("pc500_addr", mem_addr_o, 32'h0000_0500);
    wait_valid("pc500_inst", cyc);
    check("pc500_inst", inst_o, 32'h0500_FAFF);

    wait_req("pc504_req", seen_v);
    rst = 1'b1;
    tick();
    check("midwait_rst_req", {31'd0, mem_req_o}, 32'd0);
    check("midwait_rst_addr", mem_addr_o, 32'd0);
    check("midwait_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    rst = 1'b0; br_flag_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    tick();
    br_flag_i = 1'b0;
    check("idle_redirect_no_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    check("wrap_req", {31'd0, mem_req_o}, 32'd1);
    check("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
    wait_valid("wrap_inst", cyc);
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_inst", inst_o, 32'hFFFC_0003);
    wait_req("after_wrap_req", seen_v);
    check("after_wrap_addr", mem_addr_o, 32'h0000_0000);
    wait_valid("after_wrap_inst", cyc);
    check("after_wrap_inst", inst_o, 32'h0050_0093);

`ifdef IF_ICACHE_EN
    for (int k = 1; k < 4; k++) begin
      wait_req("cache_fill_req", seen_v);
      check("cache_fill_addr", mem_addr_o, 32'(k * 4));
      wait_valid("cache_fill_inst", cyc);
    end
    br_flag_i = 1'b1; br_target_i = 32'h0000_0000;
    tick();
    br_flag_i = 1'b0;
    check("cache_redirect_valid", {31'd0, inst_valid_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cache_hit_valid", {31'd0, inst_valid_o}, 32'd1);
      check("cache_hit_pc", pc_o, 32'(k * 4));
      check("cache_hit_no_req", {31'd0, mem_req_o}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("cache_cold_req", {31'd0, mem_req_o}, 32'd1);
    check("cache_cold_addr", mem_addr_o, 32'h0000_0000);
`endif

    tick(); tick();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
